load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DW, default 32, memory data width.
REQ-002 SHALL have parameter AW, default 9, memory word-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset sampled on clk.
REQ-005 SHALL have port req_valid, input, 1, CPU access request valid.
REQ-006 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port req_store, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, RV32I load/store funct3.
REQ-009 SHALL have port req_base, input, 32, rs1 value.
REQ-010 SHALL have port req_offset, input, 32, sign-extended immediate.
REQ-011 SHALL have port req_wdata, input, DW, rs2 store data.
REQ-012 SHALL have port resp_valid, output, 1, response valid.
REQ-013 SHALL have port resp_ready, input, 1, CPU accepts response.
REQ-014 SHALL have port resp_rdata, output, DW, load result, 0 for stores and faults.
REQ-015 SHALL have port resp_fault, output, 2, 00 none, 01 misaligned, 10 out of range.
REQ-016 SHALL have port mem, memory_if.master, -, connection to data memory (wr, addr, wdata, readdatasel, writedatasel, writeEnable out; rdata in).

Function
REQ-017 SHALL compute byte address ea = req_base + req_offset, modulo 2^32, with no carry flag.
REQ-018 SHALL flag misaligned when funct3[1:0]=01 and ea[0]=1, or funct3[1:0]=10 and ea[1:0]!=00; misaligned takes priority over out-of-range.
REQ-019 SHALL flag out of range when ea[31:AW+2] != 0.
REQ-020 SHALL flag illegal funct3 (store funct3>010, load funct3 011/110/111) as fault 01.
REQ-021 SHALL implement states IDLE, ISSUE, CAPTURE, RESP.
REQ-022 IDLE: req_ready=1; on req_valid latch all req fields and ea; fault -> RESP, else -> ISSUE.
REQ-023 ISSUE: drive mem.addr=ea[AW+1:2], mem.wdata=latched wdata, mem.readdatasel=funct3, mem.writedatasel=funct3[1:0], mem.writeEnable=ea[1:0], mem.wr=store; store -> RESP, load -> CAPTURE.
REQ-024 CAPTURE: register mem.rdata into resp_rdata; -> RESP.
REQ-025 RESP: resp_valid=1, outputs held stable; on resp_ready -> IDLE.
REQ-026 mem.wr SHALL be 1 only in ISSUE of a store; exactly one write pulse per accepted store.
REQ-027 Latency accept-to-resp_valid SHALL be 1 cycle fault, 2 cycles store, 3 cycles load.
REQ-028 req_ready SHALL be 0 outside IDLE; at most one request outstanding; no request accepted in the cycle RESP completes.
REQ-029 Faulting requests SHALL generate no memory access (mem.wr=0, addr unchanged).
REQ-030 In IDLE, RESP, CAPTURE mem.wr SHALL be 0; mem.addr, wdata, selects hold last ISSUE values.

Reset
REQ-031 On rst: state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=00, mem.wr=0, mem.addr=0, mem.wdata=0, mem.readdatasel=0, mem.writedatasel=0, mem.writeEnable=0.
REQ-032 rst asserted in ISSUE SHALL take priority: no write issued at that edge; in-flight request dropped, no response produced.

Structure
REQ-033 Package lsu_pkg SHALL hold state enum, fault codes, funct3 constants (LB..LHU, SB..SW).
REQ-034 Address generation and checks SHALL be combinational sub-module lsu_addr_check (ea, misaligned, out-of-range outputs).

Verification
REQ-035 SW base=0x100 off=4 data=0xDEADBEEF -> one mem.wr pulse, addr=0x41, writeEnable=00, resp_valid 2 cycles after accept, fault 00.
REQ-036 LB after storing 0x000000F0 at 0x10 (memory sign-extends), base=0x10 off=0 -> resp_rdata=0xFFFFFFF0, resp_valid 3 cycles after accept.
REQ-037 LW ea=0x102 -> fault 01 after 1 cycle, no mem.wr; LH ea=0x801 -> fault 01 (priority over range).
REQ-038 LW base=0x7FC off=8 (ea=0x804) -> fault 10; base=0xFFFFFFFC off=4 (ea wraps to 0) -> no fault, addr=0.
REQ-039 resp_ready held 0 for 5 cycles -> resp_valid/data stable, req_ready=0; rst in ISSUE of SW -> mem.wr never 1, resp_valid stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

  // Controller states: accept, drive memory, sample read data, hold response
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } lsu_state_t;

  // Response fault codes as seen on resp_fault
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } lsu_fault_t;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3 values with no RV32I meaning for the given direction
  function automatic logic funct3_illegal(input logic store, input logic [2:0] funct3);
    logic illegal;
    if (store) begin
      illegal = (funct3 > F3_SW);
    end else begin
      illegal = (funct3 != F3_LB) && (funct3 != F3_LH) && (funct3 != F3_LW) &&
                (funct3 != F3_LBU) && (funct3 != F3_LHU);
    end
    return illegal;
  endfunction

endpackage

// File: rtl/memory_if.sv
// rtl/memory_if.sv - word-addressed data memory port with size/lane selects
interface memory_if #(
  parameter int DW = 32,
  parameter int AW = 9
);
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [2:0]    readdatasel;
  logic [1:0]    writedatasel;
  logic [1:0]    writeEnable;
  logic [DW-1:0] rdata;

  // Requester side: drives the access, receives read data
  modport master (
    output wr, addr, wdata, readdatasel, writedatasel, writeEnable,
    input  rdata
  );

  // Memory side
  modport slave (
    input  wr, addr, wdata, readdatasel, writedatasel, writeEnable,
    output rdata
  );
endinterface

// File: rtl/lsu_addr_check.sv
// rtl/lsu_addr_check.sv - effective address generation with alignment and range checks
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [2:0]  funct3,
  input  logic        store,
  output logic [31:0] ea,
  output logic        misaligned,
  output logic        out_of_range
);

  // Wrapping add; illegal funct3 reports as misaligned so the top sees a single fault-01 source
  always_comb begin
    ea         = base + offset;
    misaligned = funct3_illegal(store, funct3);
    case (funct3[1:0])
      2'b01:   if (ea[0])          misaligned = 1'b1;
      2'b10:   if (ea[1:0] != 2'b00) misaligned = 1'b1;
      default: ;
    endcase
    out_of_range = |ea[31:AW+2];
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit issuing single-beat accesses to a data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_base,
  input  logic [31:0]   req_offset,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic [1:0]    resp_fault,
  memory_if.master      mem
);

  lsu_state_t  state;
  lsu_state_t  state_next;
  logic [31:0] ea;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  req_fault;
  logic        accept;
  logic        lat_store;
  logic        unused_ea_hi;

  lsu_addr_check #(.AW(AW)) u_addr_check (
    .base         (req_base),
    .offset       (req_offset),
    .funct3       (req_funct3),
    .store        (req_store),
    .ea           (ea),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  // Upper address bits only feed the range check inside the checker
  assign unused_ea_hi = ^ea[31:AW+2];

  assign accept    = (state == ST_IDLE) && req_valid;
  assign req_fault = misaligned   ? FAULT_MISALIGN :
                     out_of_range ? FAULT_RANGE    : FAULT_NONE;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs; the write strobe is gated by rst so a reset landing in ISSUE never writes
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem.wr     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (req_fault != FAULT_NONE) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem.wr     = lat_store & ~rst;
        state_next = lat_store ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the request; memory-side fields only move for accesses that will really be issued
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_store        <= 1'b0;
      mem.addr         <= '0;
      mem.wdata        <= '0;
      mem.readdatasel  <= '0;
      mem.writedatasel <= '0;
      mem.writeEnable  <= '0;
    end else if (accept) begin
      lat_store <= req_store;
      if (req_fault == FAULT_NONE) begin
        mem.addr         <= ea[AW+1:2];
        mem.wdata        <= req_wdata;
        mem.readdatasel  <= req_funct3;
        mem.writedatasel <= req_funct3[1:0];
        mem.writeEnable  <= ea[1:0];
      end
    end
  end

  // Response payload: cleared on accept, read data sampled in CAPTURE, held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_fault <= FAULT_NONE;
    end else if (accept) begin
      resp_rdata <= '0;
      resp_fault <= req_fault;
    end else if (state == ST_CAPTURE) begin
      resp_rdata <= mem.rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  localparam int DW     = 32;
  localparam int AW     = 9;
  localparam int NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_base;
  logic [31:0]   req_offset;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [1:0]    resp_fault;

  always #5 clk = ~clk;

  memory_if #(.DW(DW), .AW(AW)) mem_bus ();

  load_store_unit #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem        (mem_bus)
  );

  int n_vec;
  int n_err;
  logic busy;
  logic run_checks;
  logic clear_mem;
  logic [1:0]  exp_fault;
  logic [31:0] exp_rdata;

  // Data memory attached to the unit: lane offset from writeEnable, sign handling from readdatasel
  logic [DW-1:0] slave_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  int            wr_count;
  logic [AW-1:0] last_wr_addr;
  logic [1:0]    last_wr_we;
  logic [DW-1:0] last_wr_data;

  always_comb begin
    rd_word = slave_mem[mem_bus.addr];
    rd_byte = rd_word[{mem_bus.writeEnable, 3'b000} +: 8];
    rd_half = mem_bus.writeEnable[1] ? rd_word[31:16] : rd_word[15:0];
    case (mem_bus.readdatasel)
      3'b000:  mem_bus.rdata = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  mem_bus.rdata = {{16{rd_half[15]}}, rd_half};
      3'b100:  mem_bus.rdata = {24'b0, rd_byte};
      3'b101:  mem_bus.rdata = {16'b0, rd_half};
      default: mem_bus.rdata = rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < (1 << AW); i++) slave_mem[i] <= '0;
      wr_count <= 0;
    end else if (mem_bus.wr) begin
      case (mem_bus.writedatasel)
        2'b00:   slave_mem[mem_bus.addr][{mem_bus.writeEnable, 3'b000} +: 8] <= mem_bus.wdata[7:0];
        2'b01:   slave_mem[mem_bus.addr][{mem_bus.writeEnable[1], 4'b0000} +: 16] <= mem_bus.wdata[15:0];
        default: slave_mem[mem_bus.addr] <= mem_bus.wdata;
      endcase
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_bus.addr;
      last_wr_we   <= mem_bus.writeEnable;
      last_wr_data <= mem_bus.wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory and architectural load/store rules
  logic [7:0] ref_mem [0:NBYTES-1];

  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] o, input logic [31:0] wd,
                       output logic [1:0] flt, output logic [31:0] rd, output int lat);
    logic [31:0] ea;
    int          size;
    logic        illegal;
    ea      = b + o;
    size    = 1 << f3[1:0];
    illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    rd      = '0;
    if (illegal || (ea % size) != 0) flt = 2'b01;
    else if (ea >= NBYTES)           flt = 2'b10;
    else                             flt = 2'b00;
    if (flt != 2'b00) begin
      lat = 1;
    end else if (st) begin
      lat = 2;
      for (int i = 0; i < size; i++) ref_mem[ea + i] = wd[8*i +: 8];
    end else begin
      lat = 3;
      for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[ea + i];
      if (!f3[2] && size < 4 && rd[8*size-1])
        for (int i = size; i < 4; i++) rd[8*i +: 8] = 8'hFF;
    end
  endtask

  // Per-cycle compare of handshake and response payload against the model
  always @(negedge clk) begin
    if (run_checks && !rst) begin
      check("req_ready", {31'b0, req_ready}, {31'b0, !busy});
      if (!busy) begin
        check("resp_valid idle", {31'b0, resp_valid}, 32'h0);
        check("mem_wr idle", {31'b0, mem_bus.wr}, 32'h0);
      end else if (resp_valid) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_fault", {30'b0, resp_fault}, {30'b0, exp_fault});
      end
    end
  end

  task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                        input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                        input int hold, output logic [31:0] got_rdata, output logic [1:0] got_fault);
    logic [1:0]    flt;
    logic [31:0]   rd;
    int            exp_lat;
    int            lat;
    int            wr_before;
    logic [AW-1:0] addr_before;
    model(st, f3, b, o, wd, flt, rd, exp_lat);
    @(negedge clk);
    addr_before = mem_bus.addr;
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_base = b; req_offset = o; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    busy      = 1'b1;
    exp_fault = flt;
    exp_rdata = rd;
    wr_before = wr_count;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check({name, " latency"}, lat, exp_lat);
    repeat (hold) @(negedge clk);
    got_rdata  = resp_rdata;
    got_fault  = resp_fault;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    busy       = 1'b0;
    check({name, " writes"}, wr_count - wr_before, (st && flt == 2'b00) ? 1 : 0);
    if (flt != 2'b00) check({name, " addr held"}, {23'b0, mem_bus.addr}, {23'b0, addr_before});
  endtask

  logic [31:0] r;
  logic [1:0]  f;
  int          wr_snap;

  initial begin
    n_vec = 0; n_err = 0; busy = 1'b0; run_checks = 1'b0;
    rst = 1'b1; clear_mem = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_base = '0; req_offset = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready",    {31'b0, req_ready}, 32'h1);
    check("rst resp_valid",   {31'b0, resp_valid}, 32'h0);
    check("rst resp_rdata",   resp_rdata, 32'h0);
    check("rst resp_fault",   {30'b0, resp_fault}, 32'h0);
    check("rst mem_wr",       {31'b0, mem_bus.wr}, 32'h0);
    check("rst mem_addr",     {23'b0, mem_bus.addr}, 32'h0);
    check("rst mem_wdata",    mem_bus.wdata, 32'h0);
    check("rst readdatasel",  {29'b0, mem_bus.readdatasel}, 32'h0);
    check("rst writedatasel", {30'b0, mem_bus.writedatasel}, 32'h0);
    check("rst writeEnable",  {30'b0, mem_bus.writeEnable}, 32'h0);
    rst = 1'b0; clear_mem = 1'b0; run_checks = 1'b1;

    do_req("sw_100_4", 1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 0, r, f);
    check("sw wr addr",  {23'b0, last_wr_addr}, 32'h41);
    check("sw wr we",    {30'b0, last_wr_we}, 32'h0);
    check("sw wr data",  last_wr_data, 32'hDEADBEEF);
    check("sw fault",    {30'b0, f}, 32'h0);

    do_req("sw_10",   1'b1, 3'b010, 32'h10, 32'h0, 32'h000000F0, 0, r, f);
    do_req("lb_10",   1'b0, 3'b000, 32'h10, 32'h0, 32'h0, 0, r, f);
    check("lb literal", r, 32'hFFFFFFF0);
    do_req("lbu_10",  1'b0, 3'b100, 32'h10, 32'h0, 32'h0, 0, r, f);
    check("lbu literal", r, 32'h000000F0);
    do_req("lw_104",  1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 0, r, f);
    do_req("lh_106",  1'b0, 3'b001, 32'h100, 32'h6, 32'h0, 0, r, f);
    check("lh literal", r, 32'hFFFFDEAD);
    do_req("lhu_104", 1'b0, 3'b101, 32'h104, 32'h0, 32'h0, 0, r, f);
    do_req("lb_107",  1'b0, 3'b000, 32'h100, 32'h7, 32'h0, 0, r, f);
    do_req("sb_105",  1'b1, 3'b000, 32'h100, 32'h5, 32'h12345677, 0, r, f);
    do_req("sh_106",  1'b1, 3'b001, 32'h106, 32'h0, 32'hAAAA5555, 0, r, f);
    do_req("lw_104b", 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 0, r, f);
    check("merge literal", r, 32'h555577EF);

    do_req("lw_102",  1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 0, r, f);
    check("lw_102 fault", {30'b0, f}, 32'h1);
    do_req("lh_801",  1'b0, 3'b001, 32'h800, 32'h1, 32'h0, 0, r, f);
    check("lh_801 fault", {30'b0, f}, 32'h1);
    do_req("lw_804",  1'b0, 3'b010, 32'h7FC, 32'h8, 32'h0, 0, r, f);
    check("lw_804 fault", {30'b0, f}, 32'h2);
    do_req("sw_800",  1'b1, 3'b010, 32'h800, 32'h0, 32'h00005A5A, 0, r, f);
    do_req("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h4, 32'h0, 0, r, f);
    check("wrap fault", {30'b0, f}, 32'h0);
    check("wrap addr", {23'b0, mem_bus.addr}, 32'h0);
    do_req("st_f3_3", 1'b1, 3'b011, 32'h20, 32'h0, 32'h1, 0, r, f);
    do_req("ld_f3_6", 1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 0, r, f);
    do_req("lw_neg",  1'b0, 3'b010, 32'h110, 32'hFFFFFFF0, 32'h0, 0, r, f);
    do_req("lw_hold", 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 5, r, f);

    // Reset arriving while a store sits in ISSUE
    @(negedge clk);
    wr_snap = wr_count;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h200; req_offset = 32'h0; req_wdata = 32'h11111111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst issue wr", {31'b0, mem_bus.wr}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst issue writes", wr_count - wr_snap, 32'h0);
    check("rst issue addr", {23'b0, mem_bus.addr}, 32'h0);
    do_req("lw_200",  1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 0, r, f);
    check("lw_200 literal", r, 32'h0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
